// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for a VGA hsync/vsync pair.
// Measures line period, hsync width, frame length and vsync width on the
// pixel clock, compares them to the expected mode and tracks lock.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 1056,
  parameter int H_SYNC      = 128,
  parameter int V_TOTAL     = 628,
  parameter int V_SYNC      = 4,
  parameter int SYNC_POL    = 1,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic        frame_pulse,
  output logic [10:0] h_total_meas,
  output logic [10:0] h_sync_meas,
  output logic [10:0] v_total_meas,
  output logic [10:0] v_sync_meas,
  output logic [7:0]  err_cnt,
  output logic        sync_lost
);

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);
  localparam logic        POL_C     = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Saturating 11-bit increment: counters and measurements never wrap.
  function automatic logic [10:0] sat_inc(input logic [10:0] val, input logic inc);
    logic [11:0] sum;
    sum = {1'b0, val} + {11'd0, inc};
    if (sum[11]) begin
      sat_inc = 11'h7FF;
    end else begin
      sat_inc = sum[10:0];
    end
  endfunction

  logic        hs_r, hs_d_r, vs_r, vs_d_r;
  logic        lead_h_s, trail_h_s, lead_v_s, trail_v_s;
  logic [10:0] hcnt_r, lcnt_r, lsum_s;
  logic        h_seen_r, v_seen_r, line_bad_r;
  logic        bad_now_s, frame_ok_s, timeout_s;
  logic [3:0]  good_r, good_inc_s;
  state_t      state_r;

  // Normalise polarity (active = 1) and keep one cycle of history for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r   <= 1'b0;
      hs_d_r <= 1'b0;
      vs_r   <= 1'b0;
      vs_d_r <= 1'b0;
    end else begin
      hs_r   <= hsync_in ~^ POL_C;
      hs_d_r <= hs_r;
      vs_r   <= vsync_in ~^ POL_C;
      vs_d_r <= vs_r;
    end
  end

  // Edge strobes, line-sum with coincident lead_h, per-line and per-frame verdicts.
  always_comb begin
    lead_h_s   = hs_r & ~hs_d_r;
    trail_h_s  = ~hs_r & hs_d_r;
    lead_v_s   = vs_r & ~vs_d_r;
    trail_v_s  = ~vs_r & vs_d_r;
    lsum_s     = sat_inc(lcnt_r, lead_h_s);
    if (h_seen_r && ((lead_h_s && (hcnt_r != H_TOTAL_C)) ||
                     (trail_h_s && (hcnt_r != H_SYNC_C)))) begin
      bad_now_s = 1'b1;
    end else begin
      bad_now_s = 1'b0;
    end
    // The line closed by a lead_h coincident with lead_v belongs to the ending frame.
    frame_ok_s = v_seen_r & ~(line_bad_r | bad_now_s) &
                 (lsum_s == V_TOTAL_C) & (v_sync_meas == V_SYNC_C);
    // A lead_h on the same clock as the timeout wins.
    timeout_s  = (hcnt_r == TIMEOUT_C) & ~lead_h_s;
    good_inc_s = good_r + 4'd1;
  end

  // Horizontal/line counters, seen-flags and published measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_r       <= 11'd0;
      lcnt_r       <= 11'd0;
      h_seen_r     <= 1'b0;
      v_seen_r     <= 1'b0;
      line_bad_r   <= 1'b0;
      h_total_meas <= 11'd0;
      h_sync_meas  <= 11'd0;
      v_total_meas <= 11'd0;
      v_sync_meas  <= 11'd0;
    end else begin
      if (lead_h_s) hcnt_r <= 11'd1;
      else          hcnt_r <= sat_inc(hcnt_r, 1'b1);

      if (lead_v_s)      lcnt_r <= 11'd0;
      else if (lead_h_s) lcnt_r <= sat_inc(lcnt_r, 1'b1);
      else               lcnt_r <= lcnt_r;

      if (lead_h_s && h_seen_r)  h_total_meas <= hcnt_r;
      if (trail_h_s && h_seen_r) h_sync_meas  <= hcnt_r;
      if (lead_v_s && v_seen_r)  v_total_meas <= lsum_s;
      if (trail_v_s && v_seen_r) v_sync_meas  <= lsum_s;

      if (lead_v_s)       line_bad_r <= 1'b0;
      else if (bad_now_s) line_bad_r <= 1'b1;
      else                line_bad_r <= line_bad_r;

      // Timeout forgets all edges so stale counts are never published.
      if (lead_h_s)       h_seen_r <= 1'b1;
      else if (timeout_s) h_seen_r <= 1'b0;
      else                h_seen_r <= h_seen_r;

      if (lead_v_s)       v_seen_r <= 1'b1;
      else if (timeout_s) v_seen_r <= 1'b0;
      else                v_seen_r <= v_seen_r;
    end
  end

  // Lock state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_SEARCH;
      good_r      <= 4'd0;
      locked      <= 1'b0;
      err_cnt     <= 8'd0;
      sync_lost   <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= lead_v_s;
      if (timeout_s) begin
        state_r   <= ST_SEARCH;
        good_r    <= 4'd0;
        locked    <= 1'b0;
        sync_lost <= 1'b1;
      end else if (lead_v_s) begin
        case (state_r)
          ST_SEARCH: begin
            if (h_seen_r) begin
              state_r <= ST_CHECK;
              good_r  <= 4'd0;
            end
          end
          ST_CHECK: begin
            if (!frame_ok_s) begin
              good_r <= 4'd0;
            end else if (good_inc_s == LOCK_C) begin
              state_r   <= ST_LOCKED;
              good_r    <= good_inc_s;
              locked    <= 1'b1;
              sync_lost <= 1'b0;
            end else begin
              good_r <= good_inc_s;
            end
          end
          ST_LOCKED: begin
            if (!frame_ok_s) begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              state_r <= ST_CHECK;
              good_r  <= 4'd0;
              locked  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_SEARCH;
            good_r  <= 4'd0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
Receive-side checker for the VGA sync pair driven to the connector (800x600@60, 40 MHz pixel clock).
- Samples hsync/vsync on the pixel clock and measures the line period, hsync width, frame length in lines and vsync width.
- Compares the measurements against the expected mode and runs a lock state machine.
- Instantiated beside the top level on the same clock, or in the bench, to prove the start, game and over screens all emit legal timing across screen switches.

Parameters:
- H_TOTAL, 1056, expected clocks per line
- H_SYNC, 128, expected hsync width in clocks
- V_TOTAL, 628, expected lines per frame
- V_SYNC, 4, expected vsync width in lines
- SYNC_POL, 1, active level of both sync inputs (1 = active-high)
- LOCK_FRAMES, 2, consecutive good frames required to lock (range 1..15)
- TIMEOUT, 2047, clocks without an hsync leading edge before sync is declared lost (must be greater than H_TOTAL)

Ports:
- clk  in  1  pixel clock (VGA_CLK domain)
- rst  in  1  synchronous reset, active-high
- hsync_in  in  1  horizontal sync as driven to pin
- vsync_in  in  1  vertical sync as driven to pin
- locked  out  1  timing matches expected mode
- frame_pulse  out  1  one-cycle strobe per vsync leading edge
- h_total_meas  out  11  last measured line period, clocks
- h_sync_meas  out  11  last measured hsync width, clocks
- v_total_meas  out  11  last measured frame length, lines
- v_sync_meas  out  11  last measured vsync width, lines
- err_cnt  out  8  count of bad frames while LOCKED, saturating at 255
- sync_lost  out  1  hsync absent for TIMEOUT clocks

Behaviour:

Reset values:
- All outputs 0; FSM in SEARCH.
- Internal counters and seen-flags cleared.
- Reset asserted mid-frame aborts all measurement; the first measurement after reset is never published.

Input stage:
- hs = registered (hsync_in XNOR SYNC_POL), vs likewise, so active = 1.
- Edges detected on the registered values: lead_h, trail_h, lead_v, trail_v.

Horizontal counting:
- hcnt (11 bit) increments every clock, saturating at 2047.
- On lead_h, hcnt <= 1. An N-clock line period therefore gives hcnt = N on the next lead_h.
- On lead_h with h_seen = 1: h_total_meas <= hcnt. Then h_seen <= 1.
- On trail_h with h_seen = 1: h_sync_meas <= hcnt.

Line counting:
- lcnt (11 bit, saturating) increments on lead_h.
- On lead_v with v_seen = 1: v_total_meas <= lcnt + lead_h, then lcnt <= 0. A coincident lead_h counts toward the ending frame.
- On trail_v with v_seen = 1: v_sync_meas <= lcnt + lead_h.

Frame checking:
- line_bad (per frame) is set on any lead_h, with h_seen = 1, where hcnt != H_TOTAL.
- line_bad is also set on any trail_h, with h_seen = 1, where hcnt != H_SYNC.
- On lead_v with v_seen = 1, frame_ok = !line_bad AND (lcnt + lead_h) == V_TOTAL AND v_sync_meas == V_SYNC.
- line_bad clears on every lead_v. v_seen <= 1.
- frame_pulse = 1 for exactly the cycle after lead_v is detected (registered). Total latency from the pin is 2 clocks.

FSM transitions:
- SEARCH -> CHECK on the first lead_v with h_seen = 1; good counter cleared.
- CHECK: frame_ok increments good. When good == LOCK_FRAMES -> LOCKED and locked <= 1 on that cycle. A bad frame clears good and stays in CHECK.
- LOCKED: a bad frame increments err_cnt (saturating) and goes to CHECK with good = 0; locked <= 0 on the same cycle.

Timeout (any state):
- When hcnt reaches TIMEOUT: go to SEARCH, locked <= 0, sync_lost <= 1.
- h_seen and v_seen are cleared, so measurements do not update until fresh edges arrive.
- sync_lost clears when the FSM next enters LOCKED.

Simultaneous events and edge cases:
- When timeout and lead_h occur on the same clock, lead_h wins and the timeout is ignored.
- lead_v with h_seen = 0 keeps the FSM in SEARCH but sets v_seen.
- Sync stuck active: no lead edges occur, so timeout fires.
- Measurements saturate at 2047 and never wrap.

Test Plan:
- Reset, then 4 frames of nominal 1056/128/628/4 timing. Required: locked rises at the lead_v closing the 3rd frame, plus 2 clocks from the pin (LOCK_FRAMES = 2; the first lead_v only arms). h_total_meas = 1056, h_sync_meas = 128, v_total_meas = 628, v_sync_meas = 4, err_cnt = 0, sync_lost = 0.
- While locked, stretch one line to 1057 clocks. Required: at that frame's lead_v, locked -> 0 and err_cnt = 1. Locked returns after 2 further clean frames.
- Hold hsync_in inactive after lock. Required: 2047 clocks after the last lead_h, sync_lost = 1 and locked = 0. On resumed nominal timing, locked returns and sync_lost -> 0 on the same cycle.
- Drive vsync width 5 lines, all else nominal. Required: v_sync_meas = 5, locked never rises, err_cnt stays 0 (never locked).
- Assert rst for 1 clock mid-frame while locked. Required: all outputs 0 the next cycle. The next lead_h and lead_v do not publish measurements, and locked rises only after the arming frame plus 2 good frames.
- SYNC_POL = 0 instance with inverted nominal stimulus. Required: identical measurements and lock timing to the first scenario.
